// File: rtl/secuenciador_comparacion.sv
// Operand sequencer for the ALU equality comparator: loads A then B over one bus,
// samples the comparator result, hands it out, and keeps saturating match statistics.
module secuenciador_comparacion #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:WIDTH-1]   dato_in,
  input  logic               dato_valid,
  output logic               dato_ready,
  output logic [0:WIDTH-1]   a_out,
  output logic [0:WIDTH-1]   b_out,
  input  logic               igual_in,
  output logic               res_valid,
  output logic               res_igual,
  input  logic               res_ready,
  input  logic               limpiar,
  output logic [CNT_W-1:0]   cuenta_total,
  output logic [CNT_W-1:0]   cuenta_iguales
);

  typedef enum logic [1:0] {
    CARGA_A = 2'd0,
    CARGA_B = 2'd1,
    COMPARA = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t estado;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Handshake flags are pure decodes of the state register; rst gates ready
  // because the reset is asynchronous and state may not have settled yet.
  assign dato_ready = ~rst & ((estado == CARGA_A) | (estado == CARGA_B));
  assign res_valid  = (estado == ENTREGA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= CARGA_A;
      a_out          <= '0;
      b_out          <= '0;
      res_igual      <= 1'b0;
      cuenta_total   <= '0;
      cuenta_iguales <= '0;
    end else begin
      case (estado)
        CARGA_A: if (dato_valid) begin
          a_out  <= dato_in;
          estado <= CARGA_B;
        end
        CARGA_B: if (dato_valid) begin
          b_out  <= dato_in;
          estado <= COMPARA;
        end
        // b_out has been stable for a full cycle here, so igual_in is settled
        COMPARA: begin
          res_igual <= igual_in;
          estado    <= ENTREGA;
        end
        ENTREGA: if (res_ready) estado <= CARGA_A;
        default: estado <= CARGA_A;
      endcase

      if (limpiar) begin
        cuenta_total   <= '0;
        cuenta_iguales <= '0;
      end else if (estado == COMPARA) begin
        cuenta_total <= sat_inc(cuenta_total);
        if (igual_in) cuenta_iguales <= sat_inc(cuenta_iguales);
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_comparacion.sv
// Scoreboard bench: two sequencers (8-bit and 2-bit counters) share one stimulus
// stream; a monitor pops expected transactions on each result handshake.
module tb_secuenciador_comparacion;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:3] dato_in;
  logic       dato_valid;
  logic       res_ready;
  logic       limpiar;

  logic [0:3] a8, b8, a2, b2;
  logic       dr8, dr2, rv8, rv2, ri8, ri2, eq8, eq2;
  logic [7:0] tot8, ige8;
  logic [1:0] tot2, ige2;

  assign eq8 = (a8 == b8);
  assign eq2 = (a2 == b2);

  secuenciador_comparacion #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valid(dato_valid), .dato_ready(dr8),
    .a_out(a8), .b_out(b8), .igual_in(eq8), .res_valid(rv8), .res_igual(ri8),
    .res_ready(res_ready), .limpiar(limpiar), .cuenta_total(tot8), .cuenta_iguales(ige8));

  secuenciador_comparacion #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valid(dato_valid), .dato_ready(dr2),
    .a_out(a2), .b_out(b2), .igual_in(eq2), .res_valid(rv2), .res_igual(ri2),
    .res_ready(res_ready), .limpiar(limpiar), .cuenta_total(tot2), .cuenta_iguales(ige2));

  always #5 clk = ~clk;

  typedef struct {
    logic [0:3] a;
    logic [0:3] b;
    bit         clr;
  } tx_t;

  tx_t q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  rr_mode = 0;      // 0: res_ready high, 1: random, 2: held low
  bit  rnd_gaps = 0;
  int  m_tot8 = 0, m_ige8 = 0, m_tot2 = 0, m_ige2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  // Monitor: drives res_ready and scores each completed result handshake.
  initial begin
    tx_t t;
    res_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 3) != 0);
        default: res_ready = 1'b0;
      endcase
      if (rv8 && res_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          t = q.pop_front();
          if (t.clr) begin
            m_tot8 = 0; m_ige8 = 0; m_tot2 = 0; m_ige2 = 0;
          end else begin
            m_tot8 = sat(m_tot8, 255);
            m_tot2 = sat(m_tot2, 3);
            if (t.a == t.b) begin
              m_ige8 = sat(m_ige8, 255);
              m_ige2 = sat(m_ige2, 3);
            end
          end
          check("res_igual", ri8, (t.a == t.b));
          check("res_igual_sat", ri2, (t.a == t.b));
          check("res_valid_sat", rv2, 1);
          check("a_out", a8, t.a);
          check("b_out", b8, t.b);
          check("cuenta_total", tot8, m_tot8);
          check("cuenta_iguales", ige8, m_ige8);
          check("cuenta_total_sat", tot2, m_tot2);
          check("cuenta_iguales_sat", ige2, m_ige2);
          check("invariante", (ige8 <= tot8), 1);
        end
      end
    end
  end

  task automatic send(input logic [0:3] v);
    int gap;
    int n;
    gap = rnd_gaps ? $urandom_range(0, 2) : 0;
    repeat (gap) begin
      dato_valid = 1'b0;
      dato_in    = 4'($urandom);
      @(negedge clk);
    end
    dato_valid = 1'b1;
    dato_in    = v;
    n = 0;
    while (!dr8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("dato_ready_timeout", 0, 1);
    @(negedge clk);
    dato_valid = 1'b0;
  endtask

  // Returns on the negedge of the COMPARA cycle.
  task automatic compare(input logic [0:3] a, input logic [0:3] b, input bit clr, input bit push);
    tx_t t;
    send(a);
    send(b);
    t.a = a; t.b = b; t.clr = clr;
    if (push) q.push_back(t);
    if (clr) begin
      limpiar = 1'b1;
      @(negedge clk);
      limpiar = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || rv8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [0:3] ra, rb;
    rst = 1'b1; dato_valid = 1'b0; dato_in = '0; limpiar = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dato_ready", dr8, 0);
    check("rst_res_valid", rv8, 0);
    check("rst_a_out", a8, 0);
    check("rst_cuenta_total", tot8, 0);
    rst = 1'b0;
    #1;
    check("post_rst_dato_ready", dr8, 1);
    @(negedge clk);

    // Equal operands, with latency check
    compare(4'b1010, 4'b1010, 0, 1);
    check("lat_compara_valid", rv8, 0);
    @(negedge clk);
    check("lat_entrega_valid", rv8, 1);
    drain();
    compare(4'b1010, 4'b1011, 0, 1);
    compare(4'b1010, 4'b0010, 0, 1);
    drain();

    // Backpressure while new operands are offered
    rr_mode = 2;
    compare(4'b0110, 4'b0110, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dato_valid = 1'b1;
      dato_in    = 4'b1111;
      @(negedge clk);
      check("bp_dato_ready", dr8, 0);
      check("bp_res_valid", rv8, 1);
      check("bp_a_out", a8, 4'b0110);
      check("bp_b_out", b8, 4'b0110);
      check("bp_res_igual", ri8, 1);
    end
    rr_mode = 0;
    compare(4'b1111, 4'b0101, 0, 1);
    drain();

    // Saturation of the 2-bit counters, then clear winning over increment
    limpiar = 1'b1;
    @(negedge clk);
    limpiar = 1'b0;
    m_tot8 = 0; m_ige8 = 0; m_tot2 = 0; m_ige2 = 0;
    check("limpiar_idle", tot8, 0);
    for (int i = 0; i < 5; i++) compare(4'b1001, 4'b1001, 0, 1);
    drain();
    check("sat_total", tot2, 3);
    check("sat_iguales", ige2, 3);
    check("nosat_total", tot8, 5);
    compare(4'b0011, 4'b0011, 1, 1);
    drain();
    check("clr_total_sat", tot2, 0);
    check("clr_iguales_sat", ige2, 0);
    check("clr_total", tot8, 0);

    // Asynchronous reset in the middle of COMPARA
    compare(4'b0101, 4'b0101, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_dato_ready", dr8, 0);
    check("arst_dato_ready_sat", dr2, 0);
    check("arst_a_out", a8, 0);
    check("arst_b_out", b8, 0);
    check("arst_res_valid", rv8, 0);
    check("arst_res_igual", ri8, 0);
    check("arst_cuenta_total", tot8, 0);
    @(negedge clk);
    rst = 1'b0;
    m_tot8 = 0; m_ige8 = 0; m_tot2 = 0; m_ige2 = 0;
    #1;
    check("arst_release_ready", dr8, 1);
    @(negedge clk);
    @(negedge clk);
    check("arst_no_result", rv8, 0);
    check("arst_cuenta_iguales", ige8, 0);

    // Random transactions with random gaps and consumer stalls
    rr_mode  = 1;
    rnd_gaps = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom);
      rb = ($urandom_range(0, 1) != 0) ? ra : 4'($urandom);
      compare(ra, rb, ($urandom_range(0, 49) == 0), 1);
    end
    rr_mode = 0;
    drain();
    check("final_total", tot8, m_tot8);
    check("final_iguales", ige8, m_ige8);
    check("final_total_sat", tot2, m_tot2);
    check("final_iguales_sat", ige2, m_ige2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
